transmitter: RTL and testbench

//  UART serialiser, the TX counterpart of the RX path. Pops words from the TX FIFO and drives start bit,
//  7/8 data bits LSB-first, optional parity and one stop bit onto txOut_pin. Bit timing comes from the

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tick_edge.sv | 19 +
 rtl/transmitter.sv | 178 +++++++++++++++++
 tb/tb_transmitter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes (common to TX and RX) and parity modes.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_B0    = 4'd2,
    ST_B1    = 4'd3,
    ST_B2    = 4'd4,
    ST_B3    = 4'd5,
    ST_B4    = 4'd6,
    ST_B5    = 4'd7,
    ST_B6    = 4'd8,
    ST_B7    = 4'd9,
    ST_BP    = 4'd10,
    ST_STOP  = 4'd11
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // State that follows the last data bit: parity bit if enabled, else stop bit.
  function automatic uart_state_e after_data(input logic [1:0] mode);
    return (mode != PAR_NONE) ? ST_BP : ST_STOP;
  endfunction

endpackage

// File: rtl/uart_tick_edge.sv
// Turns a level baud enable (possibly several clk wide) into a one-clk tick on its rising edge.
module uart_tick_edge (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic enable_q;

  // Remember last cycle's enable so only the 0->1 transition produces a tick.
  always_ff @(posedge clk) begin
    if (reset) enable_q <= 1'b0;
    else       enable_q <= enable;
  end

  assign tick = enable & ~enable_q;

endmodule

// File: rtl/transmitter.sv
// UART transmit serialiser: pops words from a FWFT FIFO and shifts out start, data, parity, stop.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  IDLE     | line high, waiting for a tick with a word queued
//  START    | start bit (line low)
//  B0..B7   | data bit n, LSB first (B7 only for 8-bit words)
//  BP       | parity bit (skipped when parity is off)
//  STOP     | stop bit (line high); may chain straight into START
module transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_clk_enable,
  input  logic [1:0]        parityMode,
  input  logic              wordSize,
  input  logic              txFifo_empty,
  input  logic [DATA_W-1:0] tx_data,
  output logic              txrd_request,
  output logic              txOut_pin,
  output logic              busy,
  output logic [3:0]        state
);

  localparam int PHASE_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);

  logic tick;

  uart_tick_edge u_tick_edge (
    .clk    (clk),
    .reset  (reset),
    .enable (tx_clk_enable),
    .tick   (tick)
  );

  uart_state_e         state_q, state_d, next_bit;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [DATA_W-1:0]   shift_q, shift_d, data_m;
  logic                parity_q, parity_d, par_now;
  logic [1:0]          pmode_q, pmode_d;
  logic                word8_q, word8_d;
  logic                line_q, line_d;
  logic                rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                load;
  logic [2:0]          bit_idx;

  // Next-state, frame latching and next line level; everything advances only on a tick.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pmode_d  = pmode_q;
    word8_d  = word8_q;
    busy_d   = busy_q;
    rd_d     = 1'b0;
    load     = 1'b0;
    next_bit = ST_IDLE;
    line_d   = 1'b1;
    bit_idx  = 3'd0;

    // Parity of the incoming word, bit 7 masked off for 7-bit frames.
    data_m = tx_data;
    if (!wordSize) data_m[DATA_W-1] = 1'b0;
    case (parityMode)
      PAR_EVEN: par_now = ^data_m;
      PAR_ODD:  par_now = ~^data_m;
      PAR_MARK: par_now = 1'b1;
      default:  par_now = 1'b0;
    endcase

    case (state_q)
      ST_START:                      next_bit = ST_B0;
      ST_B0, ST_B1, ST_B2,
      ST_B3, ST_B4, ST_B5:           next_bit = uart_state_e'(state_q + 4'd1);
      ST_B6:                         next_bit = word8_q ? ST_B7 : after_data(pmode_q);
      ST_B7:                         next_bit = after_data(pmode_q);
      ST_BP:                         next_bit = ST_STOP;
      default:                       next_bit = ST_IDLE;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (tick && !txFifo_empty) load = 1'b1;
      end
      ST_START, ST_B0, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_B6, ST_B7, ST_BP: begin
        if (tick) begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            state_d = next_bit;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            if (!txFifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Frame format is frozen at pop time so mid-frame control changes are ignored.
    if (load) begin
      shift_d  = tx_data;
      pmode_d  = parityMode;
      word8_d  = wordSize;
      parity_d = par_now;
      rd_d     = 1'b1;
      busy_d   = 1'b1;
      phase_d  = '0;
      state_d  = ST_START;
    end

    // Line is registered from the upcoming state so it changes on the clk after the tick.
    case (state_d)
      ST_START: line_d = 1'b0;
      ST_B0, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_B6, ST_B7: begin
        bit_idx = 3'(state_d - ST_B0);
        line_d  = shift_d[bit_idx];
      end
      ST_BP:    line_d = parity_d;
      default:  line_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and releases the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      pmode_q  <= PAR_NONE;
      word8_q  <= 1'b0;
      line_q   <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      pmode_q  <= pmode_d;
      word8_q  <= word8_d;
      line_q   <= line_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
    end
  end

  assign txrd_request = rd_q;
  assign txOut_pin    = line_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for the UART transmitter: FIFO model plus a per-tick expected line waveform.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_clk_enable;
  logic [1:0] parityMode;
  logic       wordSize;
  logic       txFifo_empty;
  logic [7:0] tx_data;
  logic       txrd_request;
  logic       txOut_pin;
  logic       busy;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int wide = 0;
  logic rd_prev = 1'b0;

  logic       s_line, s_busy;
  logic [3:0] s_state;

  transmitter dut (
    .clk           (clk),
    .reset         (reset),
    .tx_clk_enable (tx_clk_enable),
    .parityMode    (parityMode),
    .wordSize      (wordSize),
    .txFifo_empty  (txFifo_empty),
    .tx_data       (tx_data),
    .txrd_request  (txrd_request),
    .txOut_pin     (txOut_pin),
    .busy          (busy),
    .state         (state)
  );

  always #5 clk = ~clk;

  assign txFifo_empty = (rd_ptr == wr_ptr);
  assign tx_data      = mem[rd_ptr % 16];

  // FIFO model: consume on each pop strobe, and flag strobes wider than one clk.
  always @(posedge clk) begin
    if (txrd_request) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
      if (rd_prev) wide <= wide + 1;
    end
    rd_prev <= txrd_request;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  // One baud tick: enable high for 'hi' clks, sample just after the edge that sees it.
  task automatic do_tick(input int hi);
    @(negedge clk) tx_clk_enable = 1'b1;
    @(posedge clk);
    #1;
    s_line  = txOut_pin;
    s_busy  = busy;
    s_state = state;
    repeat (hi - 1) @(posedge clk);
    @(negedge clk) tx_clk_enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Sends the nw words at the FIFO head and compares the line on every tick with the ideal frames.
  task automatic run_frames(input string tag, input int nw, input int hi, input bit chg);
    int         exp_l[$];
    int         bad_line, bad_busy, first_bad, pops0, wide0, nb, ones;
    logic [7:0] w;
    logic       ws0;
    logic [1:0] pm0;
    ws0 = wordSize;
    pm0 = parityMode;
    pops0 = pops;
    wide0 = wide;
    bad_line = 0;
    bad_busy = 0;
    first_bad = -1;
    nb = ws0 ? 8 : 7;
    for (int k = 0; k < nw; k++) begin
      int lv[$];
      w = mem[(rd_ptr + k) % 16];
      ones = 0;
      lv.push_back(0);
      for (int i = 0; i < nb; i++) begin
        lv.push_back(int'(w[i]));
        ones += int'(w[i]);
      end
      if (pm0 == 2'b01)      lv.push_back(ones % 2);
      else if (pm0 == 2'b10) lv.push_back(1 - ones % 2);
      else if (pm0 == 2'b11) lv.push_back(1);
      lv.push_back(1);
      foreach (lv[j]) for (int t = 0; t < 16; t++) exp_l.push_back(lv[j]);
    end
    for (int i = 0; i < exp_l.size(); i++) begin
      do_tick(hi);
      if (int'(s_line) != exp_l[i]) begin
        bad_line++;
        if (first_bad < 0) first_bad = i;
      end
      if (s_busy !== 1'b1) bad_busy++;
      if (chg && i == 40) begin
        wordSize   = ~ws0;
        parityMode = pm0 ^ 2'b11;
      end
    end
    check({tag, "_line_bad_ticks"}, bad_line, 0);
    if (bad_line != 0) $display("  %s first wrong tick index %0d", tag, first_bad);
    check({tag, "_busy_bad_ticks"}, bad_busy, 0);
    do_tick(hi);
    check({tag, "_end_state"}, s_state, 0);
    check({tag, "_end_line"}, s_line, 1);
    check({tag, "_end_busy"}, s_busy, 0);
    check({tag, "_pops"}, pops - pops0, nw);
    check({tag, "_wide_pops"}, wide - wide0, 0);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    tx_clk_enable = 1'b0;
    parityMode = 2'b00;
    wordSize = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line", txOut_pin, 1);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", txrd_request, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);

    // 8N1 0x55
    wordSize = 1'b1; parityMode = 2'b00; push(8'h55);
    run_frames("8n1_55", 1, 1, 0);
    // 7E1 0x41
    wordSize = 1'b0; parityMode = 2'b01; push(8'h41);
    run_frames("7e1_41", 1, 2, 0);
    // 8O1 0xFF
    wordSize = 1'b1; parityMode = 2'b10; push(8'hFF);
    run_frames("8o1_ff", 1, 3, 0);
    // 8M1 0x00
    wordSize = 1'b1; parityMode = 2'b11; push(8'h00);
    run_frames("8m1_00", 1, 1, 0);
    // back-to-back pair
    wordSize = 1'b1; parityMode = 2'b00; push(8'hA5); push(8'h3C);
    run_frames("b2b_a5_3c", 2, 2, 0);
    // 7-bit word with bit 7 set must not leak it
    wordSize = 1'b0; parityMode = 2'b10; push(8'hC1);
    run_frames("7o1_c1", 1, 1, 0);

    // reset during B3 with a second word still queued
    wordSize = 1'b1; parityMode = 2'b01;
    push(8'(($urandom_range(0, 255))));
    push(8'(($urandom_range(0, 255))));
    p0 = pops;
    for (int i = 0; i < 70; i++) do_tick(2);
    check("pre_rst_state_b3", s_state, 5);
    check("pre_rst_pops", pops - p0, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_line", txOut_pin, 1);
    check("midrst_state", state, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd", txrd_request, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pops", pops - p0, 1);
    run_frames("after_rst", 1, 3, 0);

    // 5-clk-wide enable with a format change mid-frame
    wordSize = 1'b1; parityMode = 2'b00; push(8'h96);
    run_frames("wide5_chg", 1, 5, 1);
    wordSize = 1'b0; parityMode = 2'b11; push(8'h2B);
    run_frames("wide5_chg7", 1, 5, 1);
    // very long enable pulses still count once each
    wordSize = 1'b1; parityMode = 2'b01; push(8'h6E);
    run_frames("wide40", 1, 40, 0);

    // randomized frames
    for (int r = 0; r < 6; r++) begin
      int nw;
      wordSize   = 1'($urandom_range(0, 1));
      parityMode = 2'($urandom_range(0, 3));
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) push(8'($urandom_range(0, 255)));
      run_frames($sformatf("rand%0d", r), nw, int'($urandom_range(1, 6)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
